// File: rtl/ram_pkg.sv
// Shared types, limits and the byte-merge helper for the pipelined dual-port RAM.
package ram_pkg;

  typedef enum logic {
    READ_FIRST  = 1'b0,
    WRITE_FIRST = 1'b1
  } rdw_mode_e;

  localparam int MAX_RD_LAT = 3;
  localparam int MAX_DWIDTH = 512;
  localparam int MAX_BEW    = MAX_DWIDTH / 8;

  // Per-read status carried alongside the data through the read pipeline.
  typedef struct packed {
    logic coll;
    logic err;
  } rd_meta_t;

  // Enabled bytes take new_w, all others keep old_w; callers zero-extend narrower words.
  function automatic logic [MAX_DWIDTH-1:0] be_merge(
    input logic [MAX_DWIDTH-1:0] old_w,
    input logic [MAX_DWIDTH-1:0] new_w,
    input logic [MAX_BEW-1:0]    be
  );
    logic [MAX_DWIDTH-1:0] m;
    m = old_w;
    for (int b = 0; b < MAX_BEW; b++)
      if (be[b]) m[8*b +: 8] = new_w[8*b +: 8];
    return m;
  endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Read-result delay line: RD_LAT-1 register stages behind the array output register.
module ram_rd_pipe import ram_pkg::*; #(
  parameter int RD_LAT = 1,
  parameter int DWIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  rd_meta_t          in_meta,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  output rd_meta_t          out_meta,
  output logic [DWIDTH-1:0] out_data
);

  localparam int STAGES = RD_LAT - 1;

  if (STAGES < 1) begin : g_none
    logic unused_ok;
    assign unused_ok = &{1'b0, clk, rst};
    assign out_valid = in_valid;
    assign out_meta  = in_meta;
    assign out_data  = in_data;
  end else begin : g_pipe
    logic     [STAGES-1:0]             vld_q;
    rd_meta_t [STAGES-1:0]             meta_q;
    logic     [STAGES-1:0][DWIDTH-1:0] data_q;
    logic     [STAGES:0]               vld_pipe;
    rd_meta_t [STAGES:0]               meta_pipe;
    logic     [STAGES:0][DWIDTH-1:0]   data_pipe;

    // Index 0 is the incoming stage, index STAGES is the visible output.
    assign vld_pipe  = {vld_q, in_valid};
    assign meta_pipe = {meta_q, in_meta};
    assign data_pipe = {data_q, in_data};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_q  <= '0;
        meta_q <= '0;
        data_q <= '0;
      end else begin
        vld_q  <= vld_pipe[STAGES-1:0];
        meta_q <= meta_pipe[STAGES-1:0];
        // Data only advances with a valid so the output holds between results.
        for (int s = 0; s < STAGES; s++)
          if (vld_pipe[s]) data_q[s] <= data_pipe[s];
      end
    end

    assign out_valid = vld_pipe[STAGES];
    assign out_meta  = meta_pipe[STAGES];
    assign out_data  = data_pipe[STAGES];
  end

endmodule

// File: rtl/dp_ram_pipe.sv
// Dual-port RAM (one write, one read port) with byte enables, configurable read
// latency, selectable read-during-write behaviour and collision/range flags.
module dp_ram_pipe import ram_pkg::*; #(
  parameter int DEPTH    = 16,
  parameter int DWIDTH   = 8,
  parameter int AWIDTH   = $clog2(DEPTH),
  parameter int BEW      = DWIDTH / 8,
  parameter int RD_LAT   = 1,
  parameter int RDW_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_enbl,
  input  logic [BEW-1:0]    wr_be,
  input  logic [AWIDTH-1:0] wr_addr,
  input  logic [DWIDTH-1:0] wr_data,
  input  logic              rd_enbl,
  input  logic [AWIDTH-1:0] rd_addr,
  output logic [DWIDTH-1:0] rd_data,
  output logic              rd_valid,
  output logic              rd_coll,
  output logic              rd_err
);

  localparam rdw_mode_e       MODE    = (RDW_MODE == 1) ? WRITE_FIRST : READ_FIRST;
  localparam logic [AWIDTH:0] DEPTH_W = (AWIDTH+1)'(DEPTH);

  if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
    $error("dp_ram_pipe: RD_LAT=%0d outside 1..%0d", RD_LAT, MAX_RD_LAT);
  end
  if (DWIDTH % 8 != 0 || DWIDTH > MAX_DWIDTH || BEW != DWIDTH / 8) begin : g_bad_dw
    $error("dp_ram_pipe: DWIDTH=%0d/BEW=%0d inconsistent", DWIDTH, BEW);
  end
  if (DEPTH < 2 || RDW_MODE < 0 || RDW_MODE > 1) begin : g_bad_cfg
    $error("dp_ram_pipe: DEPTH=%0d RDW_MODE=%0d illegal", DEPTH, RDW_MODE);
  end

  logic [DWIDTH-1:0] mem [DEPTH];

  logic              wr_ok, rd_ok, coll;
  logic [AWIDTH-1:0] rd_idx;
  logic [DWIDTH-1:0] rd_word, byp_word, rd_next;
  logic              s0_valid;
  rd_meta_t          s0_meta, out_meta;
  logic [DWIDTH-1:0] s0_data;

  // Compare with one extra bit so DEPTH equal to 2**AWIDTH stays representable.
  assign wr_ok  = wr_enbl && ({1'b0, wr_addr} < DEPTH_W);
  assign rd_ok  = {1'b0, rd_addr} < DEPTH_W;
  assign coll   = rd_enbl && wr_ok && rd_ok && (rd_addr == wr_addr);
  assign rd_idx = rd_ok ? rd_addr : '0;

  assign rd_word  = mem[rd_idx];
  assign byp_word = DWIDTH'(be_merge(MAX_DWIDTH'(rd_word), MAX_DWIDTH'(wr_data),
                                     MAX_BEW'(wr_be)));

  always_comb begin
    rd_next = rd_word;
    if (!rd_ok)
      rd_next = '0;
    else if (coll && MODE == WRITE_FIRST)
      rd_next = byp_word;
  end

  // Array contents survive reset; a write coinciding with reset is dropped.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok)
      for (int b = 0; b < BEW; b++)
        if (wr_be[b]) mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0_valid <= 1'b0;
      s0_meta  <= '0;
      s0_data  <= '0;
    end else begin
      s0_valid <= rd_enbl;
      s0_meta  <= '{coll: coll, err: rd_enbl && !rd_ok};
      if (rd_enbl) s0_data <= rd_next;
    end
  end

  ram_rd_pipe #(
    .RD_LAT (RD_LAT),
    .DWIDTH (DWIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (s0_valid),
    .in_meta   (s0_meta),
    .in_data   (s0_data),
    .out_valid (rd_valid),
    .out_meta  (out_meta),
    .out_data  (rd_data)
  );

  assign rd_coll = out_meta.coll;
  assign rd_err  = out_meta.err;

`ifndef SYNTHESIS
  a_ctl_known: assert property (@(posedge clk) disable iff (rst)
    !$isunknown({rd_enbl, wr_enbl}))
    else $error("dp_ram_pipe: X on rd_enbl/wr_enbl");
`endif

endmodule

// File: tb/tb_dp_ram_pipe.sv
// Directed bench: four dp_ram_pipe configurations share one stimulus stream,
// each checked against hand-computed results at its own read latency.
module tb_dp_ram_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_enbl = 1'b0;
  logic        rd_enbl = 1'b0;
  logic [3:0]  wr_be = '0;
  logic [3:0]  wr_addr = '0;
  logic [3:0]  rd_addr = '0;
  logic [31:0] wr_data = '0;

  logic [7:0]  d_a;
  logic [31:0] d_b, d_c, d_d;
  logic        v_a, v_b, v_c, v_d, c_a, c_b, c_c, c_d, e_a, e_b, e_c, e_d;
  logic [31:0] obs_d [4];
  logic [3:0]  obs_v, obs_c, obs_e;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // a: defaults; b: DEPTH12 x32 READ_FIRST lat1; c: DEPTH12 x32 WRITE_FIRST lat3; d: x32 lat2
  dp_ram_pipe #(.DEPTH(16), .DWIDTH(8), .RD_LAT(1), .RDW_MODE(0)) u_a (
    .clk(clk), .rst(rst), .wr_enbl(wr_enbl), .wr_be(wr_be[0:0]), .wr_addr(wr_addr),
    .wr_data(wr_data[7:0]), .rd_enbl(rd_enbl), .rd_addr(rd_addr),
    .rd_data(d_a), .rd_valid(v_a), .rd_coll(c_a), .rd_err(e_a));
  dp_ram_pipe #(.DEPTH(12), .DWIDTH(32), .RD_LAT(1), .RDW_MODE(0)) u_b (
    .clk(clk), .rst(rst), .wr_enbl(wr_enbl), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_enbl(rd_enbl), .rd_addr(rd_addr),
    .rd_data(d_b), .rd_valid(v_b), .rd_coll(c_b), .rd_err(e_b));
  dp_ram_pipe #(.DEPTH(12), .DWIDTH(32), .RD_LAT(3), .RDW_MODE(1)) u_c (
    .clk(clk), .rst(rst), .wr_enbl(wr_enbl), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_enbl(rd_enbl), .rd_addr(rd_addr),
    .rd_data(d_c), .rd_valid(v_c), .rd_coll(c_c), .rd_err(e_c));
  dp_ram_pipe #(.DEPTH(16), .DWIDTH(32), .RD_LAT(2), .RDW_MODE(0)) u_d (
    .clk(clk), .rst(rst), .wr_enbl(wr_enbl), .wr_be(wr_be), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_enbl(rd_enbl), .rd_addr(rd_addr),
    .rd_data(d_d), .rd_valid(v_d), .rd_coll(c_d), .rd_err(e_d));

  assign obs_d[0] = {24'h0, d_a};
  assign obs_d[1] = d_b;
  assign obs_d[2] = d_c;
  assign obs_d[3] = d_d;
  assign obs_v = {v_d, v_c, v_b, v_a};
  assign obs_c = {c_d, c_c, c_b, c_a};
  assign obs_e = {e_d, e_c, e_b, e_a};

  function automatic int lat(int i);
    case (i)
      2:       return 3;
      3:       return 2;
      default: return 1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
      else begin
        bad++;
        $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [3:0] be, input logic [31:0] d);
    wr_enbl = 1'b1; wr_addr = a; wr_be = be; wr_data = d;
    tick();
    wr_enbl = 1'b0;
  endtask

  // Issues one read (plus whatever write the caller left armed) and checks every
  // instance over the next three samples. cv/ev bit i = expected coll/err of instance i.
  task automatic rd_chk(input string tag, input logic [3:0] a,
                        input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] ec, input logic [31:0] ed,
                        input logic [3:0] cv, input logic [3:0] ev);
    logic [31:0] e [4];
    e[0] = ea; e[1] = eb; e[2] = ec; e[3] = ed;
    rd_enbl = 1'b1; rd_addr = a;
    tick();
    rd_enbl = 1'b0; wr_enbl = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) tick();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("%s u%0d k%0d valid", tag, i, k), 32'(obs_v[i]), 32'(lat(i) == k));
        if (lat(i) <= k)
          chk($sformatf("%s u%0d k%0d data", tag, i, k), obs_d[i], e[i]);
        chk($sformatf("%s u%0d k%0d coll", tag, i, k), 32'(obs_c[i]),
            (lat(i) == k) ? 32'(cv[i]) : 32'd0);
        chk($sformatf("%s u%0d k%0d err", tag, i, k), 32'(obs_e[i]),
            (lat(i) == k) ? 32'(ev[i]) : 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset u%0d valid", i), 32'(obs_v[i]), 32'd0);
      chk($sformatf("reset u%0d data", i), obs_d[i], 32'd0);
      chk($sformatf("reset u%0d coll", i), 32'(obs_c[i]), 32'd0);
      chk($sformatf("reset u%0d err", i), 32'(obs_e[i]), 32'd0);
    end
    rst = 1'b0;
    tick();

    wr(4'd3, 4'hF, 32'h0000_00A5);
    rd_chk("wr_rd", 4'd3, 32'hA5, 32'hA5, 32'hA5, 32'hA5, 4'b0000, 4'b0000);

    wr(4'd5, 4'hF, 32'h1122_3344);
    wr(4'd5, 4'b0101, 32'hAABB_CCDD);
    rd_chk("byte_en", 4'd5, 32'hDD, 32'h11BB_33DD, 32'h11BB_33DD, 32'h11BB_33DD,
           4'b0000, 4'b0000);

    wr(4'd5, 4'hF, 32'h1122_3344);
    wr_enbl = 1'b1; wr_addr = 4'd5; wr_be = 4'b0011; wr_data = 32'hFFFF_FFFF;
    rd_chk("coll", 4'd5, 32'h44, 32'h1122_3344, 32'h1122_FFFF, 32'h1122_3344,
           4'b1111, 4'b0000);
    rd_chk("post_coll", 4'd5, 32'hFF, 32'h1122_FFFF, 32'h1122_FFFF, 32'h1122_FFFF,
           4'b0000, 4'b0000);

    wr_enbl = 1'b1; wr_addr = 4'd3; wr_be = 4'b0000; wr_data = 32'hDEAD_BEEF;
    rd_chk("coll_be0", 4'd3, 32'hA5, 32'hA5, 32'hA5, 32'hA5, 4'b1111, 4'b0000);

    // Back-to-back reads: result j of every instance lands at sample j+latency.
    for (int j = 0; j < 4; j++) wr(4'(j), 4'hF, 32'hCAFE_0010 + 32'(j));
    for (int k = 1; k <= 6; k++) begin
      rd_enbl = (k <= 4);
      rd_addr = 4'(k - 1);
      tick();
      for (int i = 0; i < 4; i++) begin
        int idx;
        idx = k - lat(i);
        chk($sformatf("burst u%0d k%0d valid", i, k), 32'(obs_v[i]),
            32'(idx >= 0 && idx < 4));
        chk($sformatf("burst u%0d k%0d err", i, k), 32'(obs_e[i]), 32'd0);
        if (idx >= 0 && idx < 4)
          chk($sformatf("burst u%0d k%0d data", i, k), obs_d[i],
              (i == 0) ? 32'h10 + 32'(idx) : 32'hCAFE_0010 + 32'(idx));
      end
    end
    rd_enbl = 1'b0;

    // Address 13 is out of range for the DEPTH=12 instances (b, c) only.
    wr(4'd11, 4'hF, 32'h0BAD_F00D);
    wr(4'd13, 4'hF, 32'h0000_0055);
    wr_enbl = 1'b1; wr_addr = 4'd13; wr_be = 4'hF; wr_data = 32'h0000_0077;
    rd_chk("oor_coll", 4'd13, 32'h55, 32'h0, 32'h0, 32'h55, 4'b1001, 4'b0110);
    rd_chk("oor_rd", 4'd13, 32'h77, 32'h0, 32'h0, 32'h77, 4'b0000, 4'b0110);
    rd_chk("in_rng11", 4'd11, 32'h0D, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'h0BAD_F00D,
           4'b0000, 4'b0000);
    rd_chk("alias1", 4'd1, 32'h11, 32'hCAFE_0011, 32'hCAFE_0011, 32'hCAFE_0011,
           4'b0000, 4'b0000);

    // Reset with reads in flight in the lat2/lat3 instances.
    rd_enbl = 1'b1; rd_addr = 4'd0;
    tick();
    rd_enbl = 1'b0;
    chk("pre_rst u0 valid", 32'(obs_v[0]), 32'd1);
    rst = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mid_rst u%0d valid", i), 32'(obs_v[i]), 32'd0);
      chk($sformatf("mid_rst u%0d data", i), obs_d[i], 32'd0);
      chk($sformatf("mid_rst u%0d coll", i), 32'(obs_c[i]), 32'd0);
      chk($sformatf("mid_rst u%0d err", i), 32'(obs_e[i]), 32'd0);
    end
    wr(4'd0, 4'hF, 32'h9999_9999);
    tick();
    rst = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      for (int i = 0; i < 4; i++)
        chk($sformatf("post_rst u%0d k%0d valid", i, k), 32'(obs_v[i]), 32'd0);
    end
    rd_chk("persist", 4'd0, 32'h10, 32'hCAFE_0010, 32'hCAFE_0010, 32'hCAFE_0010,
           4'b0000, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
